// File: rtl/cache_fill_arbiter.sv
// Shared main-memory fill controller: arbitrates I/D line-fill misses (D first),
// issues one pipelined read per cycle and steers returned words into the granted cache.
module cache_fill_arbiter #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_miss,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          d_miss,
    input  logic [ADDR_W-1:0]             d_addr,
    output logic                          mem_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_data_valid,
    input  logic [15:0]                   mem_data,
    output logic                          fill_we,
    output logic                          fill_sel,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word,
    output logic [15:0]                   fill_data,
    output logic                          fill_tag_we,
    output logic                          i_done,
    output logic                          d_done,
    output logic                          busy
);
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W  = WORD_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_e;

    state_e              state_q, state_d;
    logic                grant_sel_q, grant_sel_d;
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
    logic [WORD_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic                mask_i_q, mask_i_d;
    logic                mask_d_q, mask_d_d;
    logic                req_i, req_d;

    always_comb begin
        state_d     = state_q;
        grant_sel_d = grant_sel_q;
        base_addr_d = base_addr_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        mask_i_d    = mask_i_q;
        mask_d_d    = mask_d_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_we     = 1'b0;
        fill_sel    = grant_sel_q;
        fill_word   = '0;
        fill_data   = '0;
        fill_tag_we = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        busy        = (state_q == FILL);
        req_d       = d_miss & ~mask_d_q;
        req_i       = i_miss & ~mask_i_q;

        case (state_q)
            IDLE: begin
                mask_i_d = 1'b0;
                mask_d_d = 1'b0;
                if (req_d || req_i) begin
                    state_d     = FILL;
                    grant_sel_d = req_d;
                    base_addr_d = (req_d ? d_addr : i_addr) & LINE_MASK;
                end
            end
            FILL: begin
                if (issue_cnt_q < CNT_W'(LINE_WORDS)) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_addr_q + ADDR_W'({issue_cnt_q, 1'b0});
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_data_valid) begin
                    fill_we    = 1'b1;
                    fill_word  = recv_cnt_q;
                    fill_data  = mem_data;
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    // Last word: close the line and keep the served side out of the next arbitration.
                    if (recv_cnt_q == WORD_W'(LINE_WORDS - 1)) begin
                        fill_tag_we = 1'b1;
                        i_done      = ~grant_sel_q;
                        d_done      = grant_sel_q;
                        state_d     = IDLE;
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                        mask_i_d    = ~grant_sel_q;
                        mask_d_d    = grant_sel_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_sel_q <= 1'b0;
            base_addr_q <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            mask_i_q    <= 1'b0;
            mask_d_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_sel_q <= grant_sel_d;
            base_addr_q <= base_addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            mask_i_q    <= mask_i_d;
            mask_d_q    <= mask_d_d;
        end
    end

    // A word can only come back MEM_LAT cycles after its own issue.
    always_ff @(posedge clk) begin
        if (!rst && state_q == FILL && mem_data_valid)
            assert (issue_cnt_q == CNT_W'(LINE_WORDS) ||
                    32'(issue_cnt_q) >= 32'(recv_cnt_q) + MEM_LAT);
    end
endmodule
